// File: rtl/matrix_printer_pkg.sv
// Shared constants and state encodings for the matrix UART printer.
package matrix_printer_pkg;

  // POW10[i] = 10**i; the serializer walks i from 9 down to 0.
  localparam logic [9:0][31:0] POW10 = {
    32'd1000000000, 32'd100000000, 32'd10000000, 32'd1000000, 32'd100000,
    32'd10000,      32'd1000,      32'd100,      32'd10,      32'd1
  };

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] ZERO  = 8'h30;

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StSign, StDigits, StSep, StLf, StDone
  } state_e;

  typedef enum logic [1:0] {SerIdle, SerCalc, SerOut} ser_state_e;

endpackage

// File: rtl/matrix_uart_printer_if.sv
// UART TX byte stream plus BRAM read port of the matrix printer.
interface matrix_uart_printer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 14
);
  logic [7:0]            uart_tx_data;
  logic                  uart_tx_valid;
  logic                  uart_tx_ready;
  logic [ADDR_WIDTH-1:0] bram_rd_addr;
  logic [DATA_WIDTH-1:0] bram_rd_data;

  modport master (
    output uart_tx_data, uart_tx_valid, bram_rd_addr,
    input  uart_tx_ready, bram_rd_data
  );

  modport slave (
    input  uart_tx_data, uart_tx_valid, bram_rd_addr,
    output uart_tx_ready, bram_rd_data
  );
endinterface

// File: rtl/dec_digit_serializer.sv
// Converts a 32-bit unsigned magnitude into MSB-first ASCII digits by repeated
// subtraction of powers of ten, suppressing leading zeros.
module dec_digit_serializer
  import matrix_printer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  output logic [7:0]  digit,
  output logic        digit_valid,
  output logic        digit_last,
  input  logic        digit_ready
);

  ser_state_e  state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        started_q, started_d;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    started_d   = started_q;
    digit       = ZERO + {4'd0, cnt_q};
    digit_valid = (state_q == SerOut);
    digit_last  = (idx_q == 4'd0);
    unique case (state_q)
      SerIdle: begin
        if (load) begin
          rem_d     = value;
          idx_d     = 4'd9;
          cnt_d     = 4'd0;
          started_d = 1'b0;
          state_d   = SerCalc;
        end
      end
      SerCalc: begin
        if (rem_q >= POW10[idx_q]) begin
          rem_d = rem_q - POW10[idx_q];
          cnt_d = cnt_q + 4'd1;
        end else if (cnt_q != 4'd0 || started_q || idx_q == 4'd0) begin
          state_d = SerOut;
        end else begin
          // Leading zero: drop it and move to the next power.
          idx_d = idx_q - 4'd1;
        end
      end
      SerOut: begin
        if (digit_ready) begin
          if (idx_q == 4'd0) begin
            state_d = SerIdle;
          end else begin
            idx_d     = idx_q - 4'd1;
            cnt_d     = 4'd0;
            started_d = 1'b1;
            state_d   = SerCalc;
          end
        end
      end
      default: state_d = SerIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SerIdle;
      rem_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
    end
  end

endmodule

// File: rtl/matrix_uart_printer.sv
// Reads a row-major signed matrix from BRAM and prints it as decimal text over UART TX.
// MATRIX_PRINTER_HEADER_EN: prefix the output with a "<rows> <cols>" CR LF line.
module matrix_uart_printer
  import matrix_printer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned BRAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            rows,
  input  logic [7:0]            cols,
  output logic                  busy,
  output logic                  done,
  matrix_uart_printer_if.master bus
);

`ifdef MATRIX_PRINTER_HEADER_EN
  localparam bit HeaderEn = 1'b1;
`else
  localparam bit HeaderEn = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, base_q, base_d;
  logic [7:0]            rows_q, rows_d, cols_q, cols_d;
  logic [7:0]            row_q, row_d, col_q, col_d;
  logic [1:0]            wait_q, wait_d;
  logic                  hdr_q, hdr_d, hdr_cols_q, hdr_cols_d;

  logic                  ser_load, ser_valid, ser_last, ser_ready;
  logic [31:0]           ser_value;
  logic [7:0]            ser_digit;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  data_neg, last_col;
  logic [DATA_WIDTH-1:0] data_mag;

  assign data_neg = bus.bram_rd_data[DATA_WIDTH-1];
  assign data_mag = data_neg ? -bus.bram_rd_data : bus.bram_rd_data;
  assign last_col = hdr_q ? hdr_cols_q : (col_q == cols_q - 8'd1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    base_d     = base_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    row_d      = row_q;
    col_d      = col_q;
    wait_d     = wait_q;
    hdr_d      = hdr_q;
    hdr_cols_d = hdr_cols_q;
    ser_load   = 1'b0;
    ser_value  = '0;
    ser_ready  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rows_d = rows;
          cols_d = cols;
          base_d = base_addr;
          row_d  = '0;
          col_d  = '0;
          if (HeaderEn) begin
            hdr_d      = 1'b1;
            hdr_cols_d = 1'b0;
            ser_load   = 1'b1;
            ser_value  = {24'd0, rows};
            state_d    = StDigits;
          end else if (rows == 8'd0 || cols == 8'd0) begin
            state_d = StDone;
          end else begin
            addr_d  = base_addr;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == 2'(BRAM_LATENCY - 1)) begin
          ser_load  = 1'b1;
          ser_value = 32'(data_mag);
          state_d   = data_neg ? StSign : StDigits;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StSign: begin
        tx_valid = 1'b1;
        tx_data  = MINUS;
        if (bus.uart_tx_ready) state_d = StDigits;
      end
      StDigits: begin
        // Digits pass straight through; the serializer registers valid and data.
        tx_valid  = ser_valid;
        tx_data   = ser_digit;
        ser_ready = bus.uart_tx_ready;
        if (ser_valid && bus.uart_tx_ready && ser_last) state_d = StSep;
      end
      StSep: begin
        tx_valid = 1'b1;
        tx_data  = last_col ? CR : SPACE;
        if (bus.uart_tx_ready) begin
          if (last_col) begin
            state_d = StLf;
          end else if (hdr_q) begin
            hdr_cols_d = 1'b1;
            ser_load   = 1'b1;
            ser_value  = {24'd0, cols_q};
            state_d    = StDigits;
          end else begin
            col_d   = col_q + 8'd1;
            addr_d  = addr_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StLf: begin
        tx_valid = 1'b1;
        tx_data  = LF;
        if (bus.uart_tx_ready) begin
          if (hdr_q) begin
            hdr_d = 1'b0;
            if (rows_q == 8'd0 || cols_q == 8'd0) begin
              state_d = StDone;
            end else begin
              addr_d  = base_q;
              state_d = StFetch;
            end
          end else if (row_q == rows_q - 8'd1) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + 8'd1;
            col_d   = '0;
            addr_d  = addr_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      base_q     <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wait_q     <= '0;
      hdr_q      <= 1'b0;
      hdr_cols_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wait_q     <= wait_d;
      hdr_q      <= hdr_d;
      hdr_cols_q <= hdr_cols_d;
    end
  end

  dec_digit_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .load        (ser_load),
    .value       (ser_value),
    .digit       (ser_digit),
    .digit_valid (ser_valid),
    .digit_last  (ser_last),
    .digit_ready (ser_ready)
  );

  assign bus.uart_tx_valid = tx_valid;
  assign bus.uart_tx_data  = tx_data;
  assign bus.bram_rd_addr  = addr_q;
  assign busy = (state_q != StIdle) && (state_q != StDone);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_matrix_uart_printer.sv
// Scoreboard bench: expected bytes are queued per print; a negedge monitor pops on each transfer.
module tb_matrix_uart_printer;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    rows = 8'd0;
  logic [7:0]    cols = 8'd0;
  logic          busy, done;

  matrix_uart_printer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  matrix_uart_printer #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .BRAM_LATENCY (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .rows      (rows),
    .cols      (cols),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) bus.bram_rd_data <= mem[bus.bram_rd_addr];

  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_log[$];
  int            errors = 0;
  int            checks = 0;
  int            xfers  = 0;
  int            dones  = 0;
  bit            rand_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready driver: always high, or random with a forced 5-cycle stall every 23 cycles.
  initial begin
    int cyc = 0;
    int stall = 0;
    bus.uart_tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rand_mode) bus.uart_tx_ready = 1'b1;
      else if (stall > 0) begin
        bus.uart_tx_ready = 1'b0;
        stall--;
      end else if (cyc % 23 == 0) begin
        bus.uart_tx_ready = 1'b0;
        stall = 4;
      end else bus.uart_tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: byte scoreboard, stall stability, busy during transfers, done count, address log.
  initial begin
    logic          prev_stall = 1'b0;
    logic [7:0]    prev_data = 8'h00;
    logic [7:0]    e;
    logic [AW-1:0] last_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.bram_rd_addr != last_addr) addr_log.push_back(bus.bram_rd_addr);
      last_addr = bus.bram_rd_addr;
      if (rst) prev_stall = 1'b0;
      else begin
        if (done) dones++;
        if (prev_stall) begin
          chk("hold_valid", {31'd0, bus.uart_tx_valid}, 32'd1);
          chk("hold_data", {24'd0, bus.uart_tx_data}, {24'd0, prev_data});
        end
        if (bus.uart_tx_valid && bus.uart_tx_ready) begin
          xfers++;
          chk("busy_during_tx", {31'd0, busy}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %0h expected none", bus.uart_tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", {24'd0, bus.uart_tx_data}, {24'd0, e});
          end
        end
        prev_stall = bus.uart_tx_valid && !bus.uart_tx_ready;
        prev_data  = bus.uart_tx_data;
      end
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_header(input int r, input int c);
`ifdef MATRIX_PRINTER_HEADER_EN
    push_str($sformatf("%0d %0d\015\012", r, c));
`else
    if (r < 0 || c < 0) $display("negative header dims %0d %0d", r, c);
`endif
  endtask

  task automatic kick(input logic [AW-1:0] b, input logic [7:0] r, input logic [7:0] c);
    @(posedge clk);
    #1;
    base_addr = b;
    rows      = r;
    cols      = c;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    int d0 = dones;
    while (dones == d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_done_seen"}, {31'd0, dones != d0}, 32'd1);
    repeat (4) @(posedge clk);
    chk({name, "_done_once"}, dones - d0, 32'd1);
    chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic load_2x2();
    mem[14'h0100] = 32'd1;
    mem[14'h0101] = -32'sd23;
    mem[14'h0102] = 32'd0;
    mem[14'h0103] = 32'd456;
  endtask

  initial begin
    logic [AW-1:0] a0;
    int            x0, d0, n;
    load_2x2();
    mem[14'h0200] = 32'h8000_0000;
    mem[14'h0201] = 32'h7FFF_FFFF;
    mem[14'h3FFF] = 32'd5;
    mem[14'h0000] = 32'd6;
    mem[14'h0001] = 32'd7;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.uart_tx_valid}, 32'd0);
    chk("rst_addr", {18'd0, bus.bram_rd_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // 2x2 with ready high
    push_header(2, 2);
    push_str("1 -23\015\0120 456\015\012");
    kick(14'h0100, 8'd2, 8'd2);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done("m2x2");

    // INT_MIN and INT_MAX
    push_header(1, 2);
    push_str("-2147483648 2147483647\015\012");
    kick(14'h0200, 8'd1, 8'd2);
    wait_done("extremes");

    // 2x2 under random backpressure
    rand_mode = 1'b1;
    push_header(2, 2);
    push_str("1 -23\015\0120 456\015\012");
    kick(14'h0100, 8'd2, 8'd2);
    wait_done("stall");
    rand_mode = 1'b0;

    // zero rows
    a0 = bus.bram_rd_addr;
`ifdef MATRIX_PRINTER_HEADER_EN
    push_header(0, 5);
    kick(14'h0123, 8'd0, 8'd5);
    wait_done("zero");
`else
    @(posedge clk);
    #1;
    base_addr = 14'h0123;
    rows      = 8'd0;
    cols      = 8'd5;
    start     = 1'b1;
    chk("zero_done_early", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("zero_done_pulse", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_valid", {31'd0, bus.uart_tx_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("zero_done_end", {31'd0, done}, 32'd0);
    chk("zero_busy_end", {31'd0, busy}, 32'd0);
    repeat (5) @(posedge clk);
`endif
    chk("zero_addr_held", {18'd0, bus.bram_rd_addr}, {18'd0, a0});

    // address wrap
    addr_log.delete();
    push_header(1, 3);
    push_str("5 6 7\015\012");
    kick(14'h3FFF, 8'd1, 8'd3);
    wait_done("wrap");
    chk("wrap_reads", addr_log.size(), 32'd3);
    if (addr_log.size() == 3) begin
      chk("wrap_addr0", {18'd0, addr_log[0]}, 32'h3FFF);
      chk("wrap_addr1", {18'd0, addr_log[1]}, 32'h0000);
      chk("wrap_addr2", {18'd0, addr_log[2]}, 32'h0001);
    end

    // reset mid-print, then full reprint
    push_header(2, 2);
    push_str("1 -23\015\0120 456\015\012");
    x0 = xfers;
    kick(14'h0100, 8'd2, 8'd2);
    n = 0;
    while (xfers < x0 + 4 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("mid_reached", {31'd0, xfers >= x0 + 4}, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, bus.uart_tx_valid}, 32'd0);
    chk("abort_data", {24'd0, bus.uart_tx_data}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_addr", {18'd0, bus.bram_rd_addr}, 32'd0);
    exp_q.delete();
    d0 = dones;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("abort_no_done", dones - d0, 32'd0);
    push_header(2, 2);
    push_str("1 -23\015\0120 456\015\012");
    kick(14'h0100, 8'd2, 8'd2);
    wait_done("reprint");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
